// File: rtl/pipe5_alu_core.sv
// Five-stage integer ALU pipeline (S1 fetch, S2 decode/read, S3 execute, S4 mem, then write-back) with a 32-entry regfile.
// Define FORWARD_EN to bypass EX operands from S3/S4; without it, RAW hazards interlock S1 instead.
module pipe5_alu_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic             hold,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    input  logic [4:0]       dbg_addr,
    output logic [XLEN-1:0]  dbg_data,
    output logic [CNT_W-1:0] retired,
    output logic             busy
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    logic [XLEN-1:0]  rf [32];

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [4:0]       s1_rs1, s1_rs2, s1_rd;

    logic             s2_valid;
    logic [1:0]       s2_op;
    logic [4:0]       s2_rd;
    logic [XLEN-1:0]  s2_a, s2_b;
`ifdef FORWARD_EN
    logic [4:0]       s2_rs1, s2_rs2;
`endif

    logic             s3_valid;
    logic [4:0]       s3_rd;
    logic [XLEN-1:0]  s3_data;

    logic             s4_valid;
    logic [4:0]       s4_rd;
    logic [XLEN-1:0]  s4_data;

    logic [CNT_W-1:0] retired_q;

    logic             interlock, accept, retire, wr_en;
    logic [XLEN-1:0]  rd_a, rd_b, op_a, op_b, alu;
    logic             unused_inst;

    assign unused_inst = ^in_inst[19:5];

    assign in_ready = !hold && !interlock;
    assign accept   = in_valid && in_ready;
    assign retire   = s4_valid && !hold;
    assign wr_en    = retire && (s4_rd != 5'd0);

    assign wb_valid = s4_valid;
    assign wb_rd    = s4_rd;
    assign wb_data  = s4_data;
    assign retired  = retired_q;
    assign busy     = s1_valid || s2_valid || s3_valid || s4_valid;
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

    // Decode read sees the S4 write landing at the end of this same cycle.
    always_comb begin
        rd_a = rf[s1_rs1];
        rd_b = rf[s1_rs2];
        if (s4_valid && s4_rd == s1_rs1) rd_a = s4_data;
        if (s4_valid && s4_rd == s1_rs2) rd_b = s4_data;
        if (s1_rs1 == 5'd0) rd_a = '0;
        if (s1_rs2 == 5'd0) rd_b = '0;
    end

`ifdef FORWARD_EN
    // Later assignment wins, so the younger S3 result takes priority over S4.
    always_comb begin
        op_a = s2_a;
        op_b = s2_b;
        if (s4_valid && s4_rd != 5'd0 && s4_rd == s2_rs1) op_a = s4_data;
        if (s4_valid && s4_rd != 5'd0 && s4_rd == s2_rs2) op_b = s4_data;
        if (s3_valid && s3_rd != 5'd0 && s3_rd == s2_rs1) op_a = s3_data;
        if (s3_valid && s3_rd != 5'd0 && s3_rd == s2_rs2) op_b = s3_data;
    end

    assign interlock = 1'b0;
`else
    function automatic logic dep(input logic v, input logic [4:0] rd,
                                 input logic [4:0] a, input logic [4:0] b);
        return v && (rd != 5'd0) && (rd == a || rd == b);
    endfunction

    assign op_a = s2_a;
    assign op_b = s2_b;
    // Producers in S4 are covered by the write-through read, so only S2/S3 stall.
    assign interlock = s1_valid && (dep(s2_valid, s2_rd, s1_rs1, s1_rs2) ||
                                    dep(s3_valid, s3_rd, s1_rs1, s1_rs2));
`endif

    always_comb begin
        case (s2_op)
            OP_ADD:  alu = op_a + op_b;
            OP_SUB:  alu = op_a - op_b;
            OP_AND:  alu = op_a & op_b;
            default: alu = op_a | op_b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_rd     <= '0;
            s2_valid  <= 1'b0;
            s2_op     <= '0;
            s2_rd     <= '0;
            s2_a      <= '0;
            s2_b      <= '0;
`ifdef FORWARD_EN
            s2_rs1    <= '0;
            s2_rs2    <= '0;
`endif
            s3_valid  <= 1'b0;
            s3_rd     <= '0;
            s3_data   <= '0;
            s4_valid  <= 1'b0;
            s4_rd     <= '0;
            s4_data   <= '0;
            retired_q <= '0;
        end else if (!hold) begin
            if (!interlock) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_op  <= in_inst[31:30];
                    s1_rs1 <= in_inst[29:25];
                    s1_rs2 <= in_inst[24:20];
                    s1_rd  <= in_inst[4:0];
                end
                s2_valid <= s1_valid;
                s2_op    <= s1_op;
                s2_rd    <= s1_rd;
                s2_a     <= rd_a;
                s2_b     <= rd_b;
`ifdef FORWARD_EN
                s2_rs1   <= s1_rs1;
                s2_rs2   <= s1_rs2;
`endif
            end else begin
                s2_valid <= 1'b0;
            end
            s3_valid <= s2_valid;
            s3_rd    <= s2_rd;
            s3_data  <= alu;
            s4_valid <= s3_valid;
            s4_rd    <= s3_rd;
            s4_data  <= s3_data;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[s4_rd] <= s4_data;
        end
    end

endmodule

// File: tb/tb_pipe5_alu_core.sv
// Scoreboard bench for pipe5_alu_core: an in-order ISA model predicts every write-back and the retire count.
module tb_pipe5_alu_core;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
`ifdef FORWARD_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 2;
`endif

    logic             clk, rst, in_valid, in_ready, hold, wb_valid, busy;
    logic [31:0]      in_inst;
    logic [4:0]       wb_rd, dbg_addr;
    logic [XLEN-1:0]  wb_data, dbg_data;
    logic [CNT_W-1:0] retired;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t             sb[$];
    logic [XLEN-1:0]  mreg [32];
    logic [CNT_W-1:0] exp_ret;
    int               vectors = 0;
    int               miscompares = 0;

    pipe5_alu_core #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .hold(hold), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retired(retired), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] alu_model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Write-back monitor: one sample per cycle, after the inputs of that cycle have settled.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst) begin
            vectors++;
            if (retired !== exp_ret) begin
                miscompares++;
                $display("FAIL retired_count got=%0d want=%0d t=%0t", retired, exp_ret, $time);
            end
            if (wb_valid && !hold) begin
                vectors++;
                exp_ret = exp_ret + 1'b1;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_wb got rd=%0d data=%0h want=none t=%0t", wb_rd, wb_data, $time);
                end else begin
                    e = sb.pop_front();
                    if (wb_rd !== e.rd || wb_data !== e.data) begin
                        miscompares++;
                        $display("FAIL wb_result got rd=%0d data=%0h want rd=%0d data=%0h t=%0t",
                                 wb_rd, wb_data, e.rd, e.data, $time);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, output int stalls);
        exp_t e;
        stalls = 0;
        @(negedge clk);
        in_inst  = {op, rs1, rs2, 15'd0, rd};
        in_valid = 1'b1;
        #1;
        while (!in_ready && stalls < 20) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout in_ready=%b want=1", in_ready);
            in_valid = 1'b0;
        end else begin
            e.rd   = rd;
            e.data = alu_model(op, mreg[rs1], mreg[rs2]);
            sb.push_back(e);
            if (rd != 5'd0) mreg[rd] = e.data;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while ((busy || sb.size() != 0) && n < 50);
        if (busy || sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout busy=%b pending=%0d want busy=0 pending=0", busy, sb.size());
        end
    endtask

    // No immediates exist, so nonzero values are injected into the S4 data path of an ADD rd=r0+r0.
    task automatic preload(input logic [4:0] rd, input logic [XLEN-1:0] val);
        int s;
        int n = 0;
        issue(2'd0, 5'd0, 5'd0, rd, s);
        sb[$].data = val;
        mreg[rd]   = val;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!wb_valid && n < 10);
        if (!wb_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL preload_wb_timeout wb_valid=%b want=1", wb_valid);
        end else begin
            force dut.s4_data = val;
            @(posedge clk);
            #1;
            release dut.s4_data;
        end
        drain();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== '0 || busy !== 1'b0 || retired !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got wbv=%b rd=%0d data=%0h busy=%b ret=%0d want all 0",
                     wb_valid, wb_rd, wb_data, busy, retired);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0];
            #1;
            vectors++;
            if (dbg_data !== '0) begin
                miscompares++;
                $display("FAIL reset_regfile r%0d got=%0h want=0", i, dbg_data);
            end
        end
    endtask

    task automatic test_latency();
        int s;
        int found = -1;
        issue(2'd0, 5'd0, 5'd0, 5'd1, s);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (wb_valid) begin
                found = k;
                break;
            end
        end
        vectors++;
        if (found != 3) begin
            miscompares++;
            $display("FAIL wb_latency got=%0d want=3 cycles after accept", found);
        end
        drain();
        dbg_addr = 5'd1;
        #1;
        vectors++;
        if (busy !== 1'b0 || retired !== CNT_W'(1) || dbg_data !== '0) begin
            miscompares++;
            $display("FAIL after_first busy=%b ret=%0d r1=%0h want busy=0 ret=1 r1=0", busy, retired, dbg_data);
        end
    endtask

    task automatic test_forward_stall();
        int s0, s1;
        int lows = 0;
        preload(5'd2, 32'd5);
        preload(5'd3, 32'd7);
        issue(2'd0, 5'd2, 5'd3, 5'd4, s0);
        issue(2'd1, 5'd4, 5'd2, 5'd5, s1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (!in_ready) lows++;
        end
        vectors++;
        if (s0 != 0 || s1 != 0 || lows != EXP_STALL) begin
            miscompares++;
            $display("FAIL raw_stall got s0=%0d s1=%0d low=%0d want 0 0 %0d", s0, s1, lows, EXP_STALL);
        end
        drain();
        dbg_addr = 5'd4;
        #1;
        vectors++;
        if (dbg_data !== 32'd12) begin
            miscompares++;
            $display("FAIL r4_add got=%0h want=c", dbg_data);
        end
        dbg_addr = 5'd5;
        #1;
        vectors++;
        if (dbg_data !== 32'd7) begin
            miscompares++;
            $display("FAIL r5_sub got=%0h want=7", dbg_data);
        end
    endtask

    task automatic test_alu_ops();
        int s;
        logic [4:0]      regs [5];
        logic [XLEN-1:0] want [5];
        preload(5'd7, 32'hF0);
        preload(5'd8, 32'h3C);
        preload(5'd15, 32'd1);
        issue(2'd1, 5'd0, 5'd2, 5'd6, s);
        issue(2'd2, 5'd7, 5'd8, 5'd9, s);
        issue(2'd3, 5'd7, 5'd8, 5'd10, s);
        issue(2'd1, 5'd0, 5'd15, 5'd16, s);
        issue(2'd0, 5'd16, 5'd15, 5'd17, s);
        drain();
        regs = '{5'd6, 5'd9, 5'd10, 5'd16, 5'd17};
        want = '{32'hFFFF_FFFB, 32'h30, 32'hFC, 32'hFFFF_FFFF, 32'h0};
        for (int i = 0; i < 5; i++) begin
            dbg_addr = regs[i];
            #1;
            vectors++;
            if (dbg_data !== want[i]) begin
                miscompares++;
                $display("FAIL alu_op r%0d got=%0h want=%0h", regs[i], dbg_data, want[i]);
            end
        end
    endtask

    task automatic test_r0();
        int s;
        logic [CNT_W-1:0] want_ret;
        want_ret = exp_ret + 1'b1;
        issue(2'd0, 5'd2, 5'd3, 5'd0, s);
        drain();
        dbg_addr = 5'd0;
        #1;
        vectors++;
        if (dbg_data !== '0 || retired !== want_ret) begin
            miscompares++;
            $display("FAIL r0_write got r0=%0h ret=%0d want r0=0 ret=%0d", dbg_data, retired, want_ret);
        end
    endtask

    task automatic test_hold();
        int s;
        issue(2'd0, 5'd2, 5'd3, 5'd11, s);
        issue(2'd1, 5'd11, 5'd2, 5'd12, s);
        issue(2'd2, 5'd3, 5'd7, 5'd13, s);
        @(negedge clk);
        hold     = 1'b1;
        in_valid = 1'b1;
        in_inst  = {2'd0, 5'd2, 5'd2, 15'd0, 5'd20};
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_state cycle%0d got ready=%b busy=%b want ready=0 busy=1", k, in_ready, busy);
            end
            @(negedge clk);
        end
        hold     = 1'b0;
        in_valid = 1'b0;
        issue(2'd3, 5'd11, 5'd13, 5'd14, s);
        drain();
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0];
            #1;
            vectors++;
            if (dbg_data !== mreg[i]) begin
                miscompares++;
                $display("FAIL hold_regfile r%0d got=%0h want=%0h", i, dbg_data, mreg[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int s;
        issue(2'd0, 5'd2, 5'd3, 5'd11, s);
        issue(2'd0, 5'd3, 5'd3, 5'd12, s);
        issue(2'd3, 5'd2, 5'd7, 5'd13, s);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        exp_ret  = '0;
        dbg_addr = 5'd2;
        #1;
        vectors++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== '0 ||
            retired !== '0 || dbg_data !== '0) begin
            miscompares++;
            $display("FAIL midflight_reset got busy=%b wbv=%b rd=%0d data=%0h ret=%0d r2=%0h want all 0",
                     busy, wb_valid, wb_rd, wb_data, retired, dbg_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        dbg_addr = 5'd11;
        #1;
        vectors++;
        if (busy !== 1'b0 || retired !== '0 || dbg_data !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle got busy=%b ret=%0d r11=%0h want 0 0 0", busy, retired, dbg_data);
        end
    endtask

    task automatic test_retire_wrap();
        int s;
        for (int i = 0; i < (1 << CNT_W) - 1; i++) issue(2'd0, 5'd0, 5'd0, 5'd1, s);
        drain();
        vectors++;
        if (retired !== {CNT_W{1'b1}}) begin
            miscompares++;
            $display("FAIL retired_max got=%0d want=%0d", retired, (1 << CNT_W) - 1);
        end
        issue(2'd0, 5'd0, 5'd0, 5'd1, s);
        drain();
        vectors++;
        if (retired !== '0) begin
            miscompares++;
            $display("FAIL retired_wrap got=%0d want=0", retired);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0;
        in_inst  = '0;
        hold     = 1'b0;
        dbg_addr = '0;
        rst      = 1'b0;
        exp_ret  = '0;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        #2;
        rst = 1'b1;
        test_reset();
        test_latency();
        test_forward_stall();
        test_alu_ops();
        test_r0();
        test_hold();
        test_reset_midflight();
        test_retire_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
